// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target receiver.
// Oversamples SCL/SDA on clk, detects START/STOP, ACKs writes addressed to
// DEV_ADDR and strobes each received data byte out on rx_valid. SDA is
// open-drain: the block can only pull it low through sda_oe.
module i2c_target_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       busy
);

    // A single-flop synchroniser is never safe, so depth is clamped to 2.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_DATA,
        S_ACK_DATA,
        S_IGNORE
    } state_t;

    logic [SYNC_N-1:0] scl_sync_q;
    logic [SYNC_N-1:0] sda_sync_q;
    logic              scl_d_q;
    logic              sda_d_q;

    state_t            state_q;
    logic              sda_oe_q;
    logic [7:0]        rx_data_q;
    logic              rx_valid_q;
    logic              addr_hit_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt_q;
    logic              byte_done_q;

    logic              scl;
    logic              sda;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_ev;
    logic              stop_ev;
    logic [7:0]        shift_nxt;
    logic              addr_match;

    assign scl       = scl_sync_q[SYNC_N-1];
    assign sda       = sda_sync_q[SYNC_N-1];

    assign scl_rise  = scl & ~scl_d_q;
    assign scl_fall  = ~scl & scl_d_q;
    assign start_ev  = scl & scl_d_q & sda_d_q & ~sda;
    assign stop_ev   = scl & scl_d_q & ~sda_d_q & sda;

    assign shift_nxt  = {shift_q[6:0], sda};
    assign addr_match = (shift_nxt[7:1] == DEV_ADDR) && !shift_nxt[0];

    // Synchronisers plus one history flop; reset to the idle-bus level so
    // leaving reset on an idle bus produces no spurious events.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_N-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_N-2:0], sda_in};
            scl_d_q    <= scl;
            sda_d_q    <= sda;
        end
    end

    // Protocol FSM. START/STOP override everything; sda_oe only ever
    // changes on an SCL fall so our own ACK cannot look like START/STOP.
    // In the ACK states sda_oe_q doubles as the "ACK already driven" flag:
    // the first fall drives the ACK, the second fall releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (start_ev || stop_ev) begin
                sda_oe_q    <= 1'b0;
                addr_hit_q  <= 1'b0;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                state_q     <= start_ev ? S_ADDR : S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_nxt;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= addr_match ? S_ACK_ADDR : S_IGNORE;
                            end
                        end
                    end
                    S_ACK_ADDR: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q   <= 1'b1;
                                addr_hit_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                state_q   <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_done_q) begin
                            rx_data_q   <= shift_q;
                            rx_valid_q  <= 1'b1;
                            byte_done_q <= 1'b0;
                            state_q     <= S_ACK_DATA;
                        end else if (scl_rise) begin
                            shift_q   <= shift_nxt;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q <= 1'b1;
                            end
                        end
                    end
                    S_ACK_DATA: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                state_q   <= S_DATA;
                            end
                        end
                    end
                    S_IGNORE: begin
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign addr_hit = addr_hit_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: directed I2C write transactions against i2c_target_rx.
// Stimulus pushes expected data bytes into a queue; a monitor pops and
// compares whenever rx_valid is seen.
module tb_i2c_target_rx;

    localparam int Q = 5;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_drv;
    logic       sda_drv;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    // Open-drain bus: either side may pull SDA low.
    assign scl_in = scl_drv;
    assign sda_in = sda_drv & ~sda_oe;

    i2c_target_rx #(
        .DEV_ADDR   (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .addr_hit(addr_hit),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        check("sda_oe_in_data_bit", 32'(sda_oe), 32'd0);
        tick(Q);
        scl_drv = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic ack_clk(input logic exp_ack, input string name);
        sda_drv = 1'b1;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        check(name, 32'(sda_oe), 32'(exp_ack));
        tick(Q);
        scl_drv = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b0;
        tick(Q);
        scl_drv = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_restart();
        sda_drv = 1'b1;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        sda_drv = 1'b0;
        tick(Q);
        scl_drv = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        sda_drv = 1'b1;
        tick(2 * Q);
    endtask

    // Monitor: every rx_valid strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected: got rx_data=%0h expected no strobe", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_data_strobe", 32'(rx_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        tick(3);
        check("reset_sda_oe",   32'(sda_oe),   32'd0);
        check("reset_rx_data",  32'(rx_data),  32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_addr_hit", 32'(addr_hit), 32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        reset = 1'b0;
        tick(5);

        // Single byte to our address.
        i2c_start();
        check("t1_busy_after_start", 32'(busy), 32'd1);
        send_byte(8'hA0);
        ack_clk(1'b1, "t1_addr_ack");
        check("t1_addr_hit", 32'(addr_hit), 32'd1);
        exp_q.push_back(8'hAA);
        send_byte(8'hAA);
        ack_clk(1'b1, "t1_data_ack");
        check("t1_addr_hit_held", 32'(addr_hit), 32'd1);
        i2c_stop();
        check("t1_addr_hit_after_stop", 32'(addr_hit), 32'd0);
        check("t1_busy_after_stop", 32'(busy), 32'd0);
        check("t1_rx_count", 32'(exp_q.size()), 32'd0);
        check("t1_rx_data_hold", 32'(rx_data), 32'hAA);
        tick(10);

        // Other address: ignored until STOP.
        i2c_start();
        send_byte(8'hA2);
        ack_clk(1'b0, "t2_addr_nack");
        send_byte(8'h55);
        ack_clk(1'b0, "t2_data_nack");
        check("t2_busy_ignore", 32'(busy), 32'd1);
        check("t2_addr_hit", 32'(addr_hit), 32'd0);
        i2c_stop();
        check("t2_busy_after_stop", 32'(busy), 32'd0);
        check("t2_rx_data_hold", 32'(rx_data), 32'hAA);
        tick(10);

        // Read request to our address: NACK.
        i2c_start();
        send_byte(8'hA1);
        ack_clk(1'b0, "t3_read_nack");
        check("t3_addr_hit", 32'(addr_hit), 32'd0);
        i2c_stop();
        check("t3_busy_after_stop", 32'(busy), 32'd0);
        tick(10);

        // Multi-byte write.
        i2c_start();
        send_byte(8'hA0);
        ack_clk(1'b1, "t4_addr_ack");
        exp_q.push_back(8'h12);
        send_byte(8'h12);
        ack_clk(1'b1, "t4_ack_12");
        exp_q.push_back(8'h34);
        send_byte(8'h34);
        ack_clk(1'b1, "t4_ack_34");
        exp_q.push_back(8'h56);
        send_byte(8'h56);
        ack_clk(1'b1, "t4_ack_56");
        i2c_stop();
        check("t4_rx_count", 32'(exp_q.size()), 32'd0);
        check("t4_rx_data_last", 32'(rx_data), 32'h56);
        tick(10);

        // Partial byte, repeated START, then a clean byte.
        i2c_start();
        send_byte(8'hA0);
        ack_clk(1'b1, "t5_addr_ack1");
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
        end
        i2c_restart();
        check("t5_addr_hit_after_rs", 32'(addr_hit), 32'd0);
        check("t5_busy_after_rs", 32'(busy), 32'd1);
        check("t5_rx_data_unchanged", 32'(rx_data), 32'h56);
        send_byte(8'hA0);
        ack_clk(1'b1, "t5_addr_ack2");
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        ack_clk(1'b1, "t5_data_ack");
        i2c_stop();
        check("t5_rx_count", 32'(exp_q.size()), 32'd0);
        check("t5_rx_data", 32'(rx_data), 32'h3C);
        tick(10);

        // Reset during a data ACK, then a fresh write.
        i2c_start();
        send_byte(8'hA0);
        ack_clk(1'b1, "t6_addr_ack");
        exp_q.push_back(8'h77);
        send_byte(8'h77);
        sda_drv = 1'b1;
        tick(Q);
        scl_drv = 1'b1;
        tick(Q);
        check("t6_oe_before_reset", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        check("t6_reset_sda_oe",   32'(sda_oe),   32'd0);
        check("t6_reset_busy",     32'(busy),     32'd0);
        check("t6_reset_addr_hit", 32'(addr_hit), 32'd0);
        tick(3);
        reset = 1'b0;
        tick(5);
        i2c_start();
        send_byte(8'hA0);
        ack_clk(1'b1, "t6_addr_ack2");
        exp_q.push_back(8'h99);
        send_byte(8'h99);
        ack_clk(1'b1, "t6_data_ack2");
        i2c_stop();
        check("t6_rx_data", 32'(rx_data), 32'h99);
        check("t6_busy_after_stop", 32'(busy), 32'd0);
        tick(10);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
